// File: rtl/pcpi_hub.sv
// rtl/pcpi_hub.sv - PCPI fan-out/fan-in hub for NUM_CH coprocessors; PCPI_HUB_STATS_EN adds completion/timeout counters
module pcpi_hub #(
    parameter int NUM_CH  = 4,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pcpi_valid,
    input  logic [31:0]            pcpi_insn,
    input  logic [XLEN-1:0]        pcpi_rs1,
    input  logic [XLEN-1:0]        pcpi_rs2,
    output logic                   pcpi_wr,
    output logic [XLEN-1:0]        pcpi_rd,
    output logic                   pcpi_wait,
    output logic                   pcpi_ready,
    input  logic [NUM_CH-1:0]      ch_en,
    output logic [NUM_CH-1:0]      ch_valid,
    output logic [31:0]            ch_insn,
    output logic [XLEN-1:0]        ch_rs1,
    output logic [XLEN-1:0]        ch_rs2,
    input  logic [NUM_CH-1:0]      ch_wr,
    input  logic [NUM_CH*XLEN-1:0] ch_rd,
    input  logic [NUM_CH-1:0]      ch_wait,
    input  logic [NUM_CH-1:0]      ch_ready,
`ifdef PCPI_HUB_STATS_EN
    input  logic [2:0]             stat_sel,
    output logic [15:0]            stat_cnt,
`endif
    output logic                   evt_timeout,
    output logic                   evt_collision
);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN, S_DROP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        timer;
    logic              wr_q;
    logic [XLEN-1:0]   rd_q;
    logic [NUM_CH-1:0] rdy_m, wait_m;
    logic [IW-1:0]     win_idx;
    logic [3:0]        rdy_cnt;
    logic              any_rdy, any_wait, capture, timeout_hit;

    assign ch_insn = pcpi_insn;
    assign ch_rs1  = pcpi_rs1;
    assign ch_rs2  = pcpi_rs2;

    // Lowest enabled ready channel wins; the count flags collisions.
    always_comb begin
        rdy_m    = ch_ready & ch_en;
        wait_m   = ch_wait & ch_en;
        any_rdy  = |rdy_m;
        any_wait = |wait_m;
        win_idx  = '0;
        rdy_cnt  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rdy_m[i]) win_idx = IW'(i);
            rdy_cnt = rdy_cnt + 4'(rdy_m[i]);
        end
        capture     = pcpi_valid && any_rdy && (state == S_IDLE || state == S_WAIT);
        timeout_hit = (state == S_IDLE) && pcpi_valid && !any_rdy && !any_wait &&
                      (timer == 4'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pcpi_valid) begin
                    if (any_rdy)          state_nxt = S_RESP;
                    else if (any_wait)    state_nxt = S_WAIT;
                    else if (timeout_hit) state_nxt = S_DROP;
                end
            end
            S_WAIT: begin
                if (!pcpi_valid)  state_nxt = S_IDLE;
                else if (any_rdy) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_DRAIN;
            S_DRAIN,
            S_DROP:  if (!pcpi_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ch_valid      = '0;
        pcpi_wait     = 1'b0;
        pcpi_ready    = 1'b0;
        pcpi_wr       = 1'b0;
        pcpi_rd       = rd_q;
        evt_timeout   = timeout_hit;
        evt_collision = capture && (rdy_cnt > 4'd1);
        case (state)
            S_IDLE: begin
                ch_valid  = {NUM_CH{pcpi_valid}} & ch_en;
                pcpi_wait = any_wait;
            end
            S_WAIT: begin
                ch_valid  = {NUM_CH{pcpi_valid}} & ch_en;
                pcpi_wait = 1'b1;
            end
            S_RESP: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = wr_q;
            end
            default: ;
        endcase
    end

    // Timer counts only while an unclaimed request sits in IDLE; WAIT freezes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= '0;
            wr_q  <= 1'b0;
            rd_q  <= '0;
        end else begin
            if (state == S_IDLE && pcpi_valid && state_nxt == S_IDLE)
                timer <= timer + 4'd1;
            else if (!(state == S_WAIT && state_nxt == S_WAIT))
                timer <= '0;
            if (capture) begin
                wr_q <= ch_wr[win_idx];
                rd_q <= ch_rd[win_idx*XLEN +: XLEN];
            end
        end
    end

`ifdef PCPI_HUB_STATS_EN
    logic [15:0] comp_cnt [NUM_CH];
    logic [15:0] tmo_cnt;
    logic [15:0] stat_nxt;

    always_comb begin
        stat_nxt = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (3'(i) == stat_sel) stat_nxt = comp_cnt[i];
        if (stat_sel == 3'd7) stat_nxt = tmo_cnt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) comp_cnt[i] <= '0;
            tmo_cnt  <= '0;
            stat_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (capture && win_idx == IW'(i) && comp_cnt[i] != 16'hFFFF)
                    comp_cnt[i] <= comp_cnt[i] + 16'd1;
            if (timeout_hit && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
            stat_cnt <= stat_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pcpi_hub.sv
// tb/tb_pcpi_hub.sv - directed bench for pcpi_hub with a request-level reference model
module tb_pcpi_hub;
    localparam int NCH = 4;
    localparam int XL  = 32;
    localparam int TMO = 12;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic              pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0]       pcpi_insn, ch_insn;
    logic [XL-1:0]     pcpi_rs1, pcpi_rs2, pcpi_rd, ch_rs1, ch_rs2;
    logic [NCH-1:0]    ch_en, ch_valid, ch_wr, ch_wait, ch_ready;
    logic [NCH*XL-1:0] ch_rd;
    logic              evt_timeout, evt_collision;
`ifdef PCPI_HUB_STATS_EN
    logic [2:0]        stat_sel;
    logic [15:0]       stat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pcpi_hub #(.NUM_CH(NCH), .XLEN(XL), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .ch_en(ch_en), .ch_valid(ch_valid), .ch_insn(ch_insn), .ch_rs1(ch_rs1), .ch_rs2(ch_rs2),
        .ch_wr(ch_wr), .ch_rd(ch_rd), .ch_wait(ch_wait), .ch_ready(ch_ready),
`ifdef PCPI_HUB_STATS_EN
        .stat_sel(stat_sel), .stat_cnt(stat_cnt),
`endif
        .evt_timeout(evt_timeout), .evt_collision(evt_collision)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request-level model: a request is open, claimed, answered (one pulse) or closed until valid drops.
    bit             m_claimed, m_closed, m_pend, m_wr;
    logic [XL-1:0]  m_rd;
    int             m_age;
    logic [NCH-1:0] rm, wm;
    bit             open;
    int             pc, win;

    always @(negedge clk) begin
        if (!resetn) begin
            m_claimed = 0; m_closed = 0; m_pend = 0; m_wr = 0; m_rd = '0; m_age = 0;
        end else begin
            rm = ch_ready & ch_en;
            wm = ch_wait & ch_en;
            open = pcpi_valid && !m_closed && !m_pend;
            pc = 0;
            win = -1;
            for (int i = NCH - 1; i >= 0; i--) if (rm[i]) begin pc++; win = i; end
            chk("m_ch_valid", ch_valid, open ? ch_en : {NCH{1'b0}});
            chk("m_ch_insn", ch_insn, pcpi_insn);
            chk("m_ch_rs", {ch_rs1, ch_rs2}, {pcpi_rs1, pcpi_rs2});
            chk("m_pcpi_ready", pcpi_ready, m_pend);
            chk("m_pcpi_wr", pcpi_wr, m_pend && m_wr);
            chk("m_pcpi_rd", pcpi_rd, m_rd);
            chk("m_pcpi_wait", pcpi_wait, m_claimed || (!m_closed && !m_pend && wm != 0));
            chk("m_evt_collision", evt_collision, open && pc > 1);
            chk("m_evt_timeout", evt_timeout,
                open && !m_claimed && pc == 0 && wm == 0 && m_age == TMO - 1);
            if (m_pend) begin
                m_pend = 0; m_closed = 1;
            end else if (m_closed) begin
                if (!pcpi_valid) m_closed = 0;
            end else if (!pcpi_valid) begin
                m_claimed = 0; m_age = 0;
            end else if (pc > 0) begin
                m_wr = ch_wr[win]; m_rd = ch_rd[win*XL +: XL];
                m_pend = 1; m_claimed = 0; m_age = 0;
            end else if (!m_claimed) begin
                if (wm != 0)                begin m_claimed = 1; m_age = 0; end
                else if (m_age == TMO - 1)  begin m_closed = 1;  m_age = 0; end
                else                        m_age++;
            end
        end
    end

    task automatic complete(input int ch, input logic [31:0] v);
        pcpi_valid = 1'b1;
        tick();
        ch_ready[ch] = 1'b1; ch_wr[ch] = 1'b1; ch_rd[ch*XL +: XL] = v;
        tick();
        ch_ready = '0; ch_wr = '0;
        tick();
        pcpi_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        pcpi_valid = 0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        ch_en = 4'hF; ch_wr = '0; ch_rd = '0; ch_wait = '0; ch_ready = '0;
`ifdef PCPI_HUB_STATS_EN
        stat_sel = 3'd0;
`endif
        #3;
        chk("rst_ready", pcpi_ready, 0);
        chk("rst_wr", pcpi_wr, 0);
        chk("rst_rd", pcpi_rd, 0);
        chk("rst_wait", pcpi_wait, 0);
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_evt", {evt_timeout, evt_collision}, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // Claim by ch1 at cycle 1, answer at cycle 5
        pcpi_valid = 1; pcpi_insn = 32'h02B50533; pcpi_rs1 = 32'd6; pcpi_rs2 = 32'd7;
        for (int c = 0; c < 9; c++) begin
            ch_wait[1]  = (c >= 1 && c <= 5);
            ch_ready[1] = (c == 5);
            ch_wr[1]    = (c == 5);
            ch_rd[XL +: XL] = (c == 5) ? 32'hDEADBEEF : 32'h0;
            if (c == 7) pcpi_valid = 0;
            @(negedge clk);
            chk("t1_wait", pcpi_wait, (c >= 1 && c <= 5));
            chk("t1_ready", pcpi_ready, (c == 6));
            if (c == 0) begin
                chk("t1_ch_insn", ch_insn, 32'h02B50533);
                chk("t1_ch_valid0", ch_valid, 4'hF);
            end
            if (c == 6) begin
                chk("t1_rd", pcpi_rd, 32'hDEADBEEF);
                chk("t1_wr", pcpi_wr, 1);
            end
            if (c >= 6) chk("t1_ch_valid_off", ch_valid, 0);
            tick();
        end
        ch_wait = '0; ch_ready = '0; ch_wr = '0; ch_rd = '0;

        // Nobody answers: drop at cycle 11
        pcpi_valid = 1; pcpi_insn = 32'h0000_0013;
        for (int c = 0; c < 19; c++) begin
            if (c == 15) pcpi_valid = 0;
            if (c == 17) pcpi_valid = 1;
            if (c == 18) pcpi_valid = 0;
            @(negedge clk);
            chk("t2_timeout", evt_timeout, (c == 11));
            chk("t2_ready", pcpi_ready, 0);
            if (c >= 12 && c <= 16) chk("t2_ch_valid_off", ch_valid, 0);
            if (c == 17) chk("t2_idle_again", ch_valid, 4'hF);
            tick();
        end

        // ch0 and ch2 ready together
        pcpi_valid = 1;
        for (int c = 0; c < 5; c++) begin
            ch_ready = (c == 1) ? 4'b0101 : 4'b0000;
            ch_wr    = (c == 1) ? 4'b0101 : 4'b0000;
            ch_rd[0 +: XL]    = 32'h1;
            ch_rd[2*XL +: XL] = 32'h2;
            if (c == 3) pcpi_valid = 0;
            @(negedge clk);
            chk("t3_collision", evt_collision, (c == 1));
            if (c == 2) begin
                chk("t3_ready", pcpi_ready, 1);
                chk("t3_rd", pcpi_rd, 32'h1);
            end
            tick();
        end
        ch_rd = '0;

        // Disabled ch1 ready is ignored
        ch_en = 4'b1101; pcpi_valid = 1;
        ch_ready[1] = 1; ch_wr[1] = 1; ch_rd[XL +: XL] = 32'hBAD;
        for (int c = 0; c < 14; c++) begin
            if (c == 12) pcpi_valid = 0;
            @(negedge clk);
            chk("t4_ch_valid", ch_valid, (c <= 11) ? 4'b1101 : 4'b0000);
            chk("t4_timeout", evt_timeout, (c == 11));
            chk("t4_ready", pcpi_ready, 0);
            tick();
        end
        ch_en = 4'hF; ch_ready = '0; ch_wr = '0; ch_rd = '0;

        // Async reset while WAIT
        pcpi_valid = 1; ch_wait[2] = 1;
        tick();
        @(negedge clk);
        chk("t5_in_wait", pcpi_wait, 1);
        #2;
        resetn = 0; pcpi_valid = 0; ch_wait = '0;
        #1;
        chk("t5_rst_ch_valid", ch_valid, 0);
        chk("t5_rst_wait", pcpi_wait, 0);
        chk("t5_rst_rd", pcpi_rd, 0);
        chk("t5_rst_ready_wr", {pcpi_ready, pcpi_wr}, 0);
        tick(); tick();
        resetn = 1;
        tick();
        pcpi_valid = 1; pcpi_insn = 32'h02C5F5B3;
        for (int c = 0; c < 5; c++) begin
            ch_ready[0] = (c == 1);
            ch_rd[0 +: XL] = 32'h12345678;
            if (c == 3) pcpi_valid = 0;
            @(negedge clk);
            chk("t5_ready", pcpi_ready, (c == 2));
            if (c == 2) begin
                chk("t5_rd", pcpi_rd, 32'h12345678);
                chk("t5_wr", pcpi_wr, 0);
            end
            tick();
        end
        ch_ready = '0; ch_rd = '0;

        // Three ch3 completions and one drop
        complete(3, 32'hA);
        complete(3, 32'hB);
        complete(3, 32'hC);
        @(negedge clk);
        chk("t6_last_rd", pcpi_rd, 32'hC);
        tick();
        pcpi_valid = 1;
        repeat (13) tick();
        pcpi_valid = 0;
        tick(); tick();
`ifdef PCPI_HUB_STATS_EN
        stat_sel = 3'd3; tick(); @(negedge clk); chk("st_ch3", stat_cnt, 3); tick();
        stat_sel = 3'd7; tick(); @(negedge clk); chk("st_tmo", stat_cnt, 1); tick();
        stat_sel = 3'd5; tick(); @(negedge clk); chk("st_oob", stat_cnt, 0); tick();
        stat_sel = 3'd0; tick(); @(negedge clk); chk("st_ch0", stat_cnt, 1); tick();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
